riscv_multicycle_ctrl: RTL

Multi-cycle RISC-V RV32I control FSM that replaces the single-cycle decoder. It sequences one instruction over 3–5 states on a shared ALU and a unified instruction/data memory. It waits on a memory ready handshake, resolves BEQ/BNE/BLT/BGE from ALU flags, and traps illegal opcodes. It also maintains a retired-instruction counter.

---
 rtl/riscv_ctrl_pkg.sv | 78 +++++++
 rtl/branch_cond_unit.sv | 25 ++
 rtl/riscv_multicycle_ctrl.sv | 235 +++++++++++++++++++++++
 3 files changed

// File: rtl/riscv_ctrl_pkg.sv
// Shared encodings for the multi-cycle RV32I control FSM: opcodes, branch
// funct3 codes, datapath select values, state enum and the control bundle.
package riscv_ctrl_pkg;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;

  localparam logic [2:0] F3_BEQ = 3'b000;
  localparam logic [2:0] F3_BNE = 3'b001;
  localparam logic [2:0] F3_BLT = 3'b100;
  localparam logic [2:0] F3_BGE = 3'b101;

  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_RS1   = 2'b10;

  localparam logic [1:0] SRCB_RS2  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  localparam logic [1:0] ALU_ADD   = 2'b00;
  localparam logic [1:0] ALU_SUB   = 2'b01;
  localparam logic [1:0] ALU_FUNCT = 2'b10;

  localparam logic [2:0] IMM_I = 3'b000;
  localparam logic [2:0] IMM_S = 3'b001;
  localparam logic [2:0] IMM_B = 3'b010;
  localparam logic [2:0] IMM_U = 3'b011;
  localparam logic [2:0] IMM_J = 3'b100;

  localparam logic [1:0] RES_ALUOUT = 2'b00;
  localparam logic [1:0] RES_DATA   = 2'b01;
  localparam logic [1:0] RES_ALU    = 2'b10;
  localparam logic [1:0] RES_IMM    = 2'b11;

  typedef enum logic [3:0] {
    S_FETCH     = 4'd0,
    S_DECODE    = 4'd1,
    S_MEM_ADR   = 4'd2,
    S_MEM_READ  = 4'd3,
    S_MEM_WB    = 4'd4,
    S_MEM_WRITE = 4'd5,
    S_EXEC_R    = 4'd6,
    S_EXEC_I    = 4'd7,
    S_ALU_WB    = 4'd8,
    S_BRANCH    = 4'd9,
    S_JAL       = 4'd10,
    S_JALR      = 4'd11,
    S_JALR_PC   = 4'd12,
    S_LUI       = 4'd13,
    S_HALT      = 4'd14
  } state_e;

  typedef struct packed {
    logic       mem_req;
    logic       mem_write;
    logic       adr_src;
    logic       ir_write;
    logic       pc_write;
    logic       reg_write;
    logic [1:0] alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [2:0] imm_src;
    logic [1:0] result_src;
    logic       instr_done;
    logic       illegal;
  } ctrl_t;

  localparam ctrl_t CTRL_NONE = ctrl_t'({$bits(ctrl_t){1'b0}});

endpackage

// File: rtl/branch_cond_unit.sv
// Branch resolution from ALU flags of rs1-rs2; flags unsupported funct3 codes.
module branch_cond_unit
  import riscv_ctrl_pkg::*;
(
  input  logic [2:0] funct3,
  input  logic       zero,
  input  logic       neg,
  output logic       taken,
  output logic       bad_funct3
);

  // Decode the branch condition for the supported compare types
  always_comb begin
    taken      = 1'b0;
    bad_funct3 = 1'b0;
    case (funct3)
      F3_BEQ:  taken = zero;
      F3_BNE:  taken = ~zero;
      F3_BLT:  taken = neg;
      F3_BGE:  taken = ~neg;
      default: bad_funct3 = 1'b1;
    endcase
  end

endmodule

// File: rtl/riscv_multicycle_ctrl.sv
// Multi-cycle RV32I control FSM: sequences one instruction over a shared ALU
// and unified memory, resolves branches, traps illegal opcodes, counts retires.
module riscv_multicycle_ctrl
  import riscv_ctrl_pkg::*;
#(
  parameter bit MEM_HANDSHAKE   = 1'b1,
  parameter bit TRAP_ON_ILLEGAL = 1'b1,
  parameter int CNT_W           = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [6:0]       opcode,
  input  logic [2:0]       funct3,
  input  logic             zero,
  input  logic             neg,
  input  logic             mem_ready,
  output logic             mem_req,
  output logic             mem_write,
  output logic             adr_src,
  output logic             ir_write,
  output logic             pc_write,
  output logic             reg_write,
  output logic [1:0]       alu_src_a,
  output logic [1:0]       alu_src_b,
  output logic [1:0]       alu_op,
  output logic [2:0]       imm_src,
  output logic [1:0]       result_src,
  output logic             instr_done,
  output logic             illegal,
  output logic [CNT_W-1:0] instret
);

  state_e           state_r;
  state_e           next_s;
  ctrl_t            ctl_s;
  ctrl_t            ctl_o;
  logic             rdy_s;
  logic             taken_s;
  logic             bad_f3_s;
  logic [CNT_W-1:0] instret_r;

  assign rdy_s = MEM_HANDSHAKE ? mem_ready : 1'b1;

  branch_cond_unit u_branch (
    .funct3     (funct3),
    .zero       (zero),
    .neg        (neg),
    .taken      (taken_s),
    .bad_funct3 (bad_f3_s)
  );

  // Next state and Moore decode of the current state (mem_ready/flag qualified strobes)
  always_comb begin
    next_s = state_r;
    ctl_s  = CTRL_NONE;
    case (state_r)
      S_FETCH: begin
        ctl_s.mem_req    = 1'b1;
        ctl_s.alu_src_a  = SRCA_PC;
        ctl_s.alu_src_b  = SRCB_FOUR;
        ctl_s.alu_op     = ALU_ADD;
        ctl_s.result_src = RES_ALU;
        ctl_s.ir_write   = rdy_s;
        ctl_s.pc_write   = rdy_s;
        if (rdy_s) next_s = S_DECODE;
        else       next_s = S_FETCH;
      end
      S_DECODE: begin
        ctl_s.alu_src_a = SRCA_OLDPC;
        ctl_s.alu_src_b = SRCB_IMM;
        ctl_s.imm_src   = IMM_B;
        case (opcode)
          OP_LOAD, OP_STORE: next_s = S_MEM_ADR;
          OP_RTYPE:          next_s = S_EXEC_R;
          OP_ITYPE:          next_s = S_EXEC_I;
          OP_BRANCH:         next_s = S_BRANCH;
          OP_JAL:            next_s = S_JAL;
          OP_JALR:           next_s = S_JALR;
          OP_LUI:            next_s = S_LUI;
          default: begin
            if (TRAP_ON_ILLEGAL) begin
              next_s = S_HALT;
            end else begin
              ctl_s.illegal    = 1'b1;
              ctl_s.instr_done = 1'b1;
              next_s           = S_FETCH;
            end
          end
        endcase
      end
      S_MEM_ADR: begin
        ctl_s.alu_src_a = SRCA_RS1;
        ctl_s.alu_src_b = SRCB_IMM;
        ctl_s.alu_op    = ALU_ADD;
        if (opcode == OP_STORE) begin
          ctl_s.imm_src = IMM_S;
          next_s        = S_MEM_WRITE;
        end else begin
          ctl_s.imm_src = IMM_I;
          next_s        = S_MEM_READ;
        end
      end
      S_MEM_READ: begin
        ctl_s.mem_req = 1'b1;
        ctl_s.adr_src = 1'b1;
        if (rdy_s) next_s = S_MEM_WB;
        else       next_s = S_MEM_READ;
      end
      S_MEM_WB: begin
        ctl_s.result_src = RES_DATA;
        ctl_s.reg_write  = 1'b1;
        ctl_s.instr_done = 1'b1;
        next_s           = S_FETCH;
      end
      S_MEM_WRITE: begin
        ctl_s.mem_req    = 1'b1;
        ctl_s.mem_write  = 1'b1;
        ctl_s.adr_src    = 1'b1;
        ctl_s.imm_src    = IMM_S;
        ctl_s.instr_done = rdy_s;
        if (rdy_s) next_s = S_FETCH;
        else       next_s = S_MEM_WRITE;
      end
      S_EXEC_R: begin
        ctl_s.alu_src_a = SRCA_RS1;
        ctl_s.alu_src_b = SRCB_RS2;
        ctl_s.alu_op    = ALU_FUNCT;
        next_s          = S_ALU_WB;
      end
      S_EXEC_I: begin
        ctl_s.alu_src_a = SRCA_RS1;
        ctl_s.alu_src_b = SRCB_IMM;
        ctl_s.alu_op    = ALU_FUNCT;
        ctl_s.imm_src   = IMM_I;
        next_s          = S_ALU_WB;
      end
      S_ALU_WB: begin
        ctl_s.result_src = RES_ALUOUT;
        ctl_s.reg_write  = 1'b1;
        ctl_s.instr_done = 1'b1;
        next_s           = S_FETCH;
      end
      S_BRANCH: begin
        ctl_s.alu_src_a  = SRCA_RS1;
        ctl_s.alu_src_b  = SRCB_RS2;
        ctl_s.alu_op     = ALU_SUB;
        ctl_s.result_src = RES_ALUOUT;
        ctl_s.imm_src    = IMM_B;
        if (bad_f3_s) begin
          if (TRAP_ON_ILLEGAL) begin
            next_s = S_HALT;
          end else begin
            ctl_s.illegal    = 1'b1;
            ctl_s.instr_done = 1'b1;
            next_s           = S_FETCH;
          end
        end else begin
          ctl_s.pc_write   = taken_s;
          ctl_s.instr_done = 1'b1;
          next_s           = S_FETCH;
        end
      end
      S_JAL: begin
        ctl_s.alu_src_a  = SRCA_OLDPC;
        ctl_s.alu_src_b  = SRCB_FOUR;
        ctl_s.result_src = RES_ALUOUT;
        ctl_s.imm_src    = IMM_J;
        ctl_s.pc_write   = 1'b1;
        next_s           = S_ALU_WB;
      end
      S_JALR: begin
        ctl_s.alu_src_a = SRCA_RS1;
        ctl_s.alu_src_b = SRCB_IMM;
        ctl_s.imm_src   = IMM_I;
        next_s          = S_JALR_PC;
      end
      S_JALR_PC: begin
        ctl_s.alu_src_a  = SRCA_OLDPC;
        ctl_s.alu_src_b  = SRCB_FOUR;
        ctl_s.result_src = RES_ALUOUT;
        ctl_s.pc_write   = 1'b1;
        next_s           = S_ALU_WB;
      end
      S_LUI: begin
        ctl_s.result_src = RES_IMM;
        ctl_s.imm_src    = IMM_U;
        ctl_s.reg_write  = 1'b1;
        ctl_s.instr_done = 1'b1;
        next_s           = S_FETCH;
      end
      S_HALT: begin
        ctl_s.illegal = 1'b1;
        next_s        = S_HALT;
      end
      default: begin
        next_s = S_FETCH;
      end
    endcase
  end

  // Reset overrides the decode so nothing leaks out while rst is held
  always_comb begin
    if (rst) ctl_o = CTRL_NONE;
    else     ctl_o = ctl_s;
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_r <= S_FETCH;
    else     state_r <= next_s;
  end

  // Retired-instruction counter, wraps naturally at 2^CNT_W
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                   instret_r <= {CNT_W{1'b0}};
    else if (ctl_o.instr_done) instret_r <= instret_r + {{(CNT_W-1){1'b0}}, 1'b1};
    else                       instret_r <= instret_r;
  end

  assign mem_req    = ctl_o.mem_req;
  assign mem_write  = ctl_o.mem_write;
  assign adr_src    = ctl_o.adr_src;
  assign ir_write   = ctl_o.ir_write;
  assign pc_write   = ctl_o.pc_write;
  assign reg_write  = ctl_o.reg_write;
  assign alu_src_a  = ctl_o.alu_src_a;
  assign alu_src_b  = ctl_o.alu_src_b;
  assign alu_op     = ctl_o.alu_op;
  assign imm_src    = ctl_o.imm_src;
  assign result_src = ctl_o.result_src;
  assign instr_done = ctl_o.instr_done;
  assign illegal    = ctl_o.illegal;
  assign instret    = instret_r;

endmodule
